alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Single-entry ID/EX pipeline register that sits directly upstream of the ALU.
- Captures decoded operands, applies EX/MEM and MEM/WB result forwarding, and selects the immediate for operand B.
- Presents A, B and ALUCtrl to the ALU through a valid/ready handshake.
- A held entry keeps snooping the forwarding buses, so its operands stay current across stalls.

Parameters:
- XLEN, 64, datapath width (A, B, results).
- RA_W, 5, register address width.
- CTRL_W, 4, ALU control width (ALUCtrl encoding).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has a decoded instruction
- in_ready  out  1  stage can accept this cycle
- in_rs1_addr  in  RA_W  source register 1
- in_rs2_addr  in  RA_W  source register 2
- in_rs1_data  in  XLEN  register-file value for rs1
- in_rs2_data  in  XLEN  register-file value for rs2
- in_imm  in  XLEN  sign-extended immediate
- in_use_imm  in  1  B takes in_imm instead of rs2
- in_alu_ctrl  in  CTRL_W  ALU operation code
- in_rd_addr  in  RA_W  destination register
- in_rd_we  in  1  destination write enable
- flush  in  1  squash the held entry and any capture this cycle
- exmem_rd_addr  in  RA_W  EX/MEM destination
- exmem_rd_we  in  1  EX/MEM writes a register
- exmem_result  in  XLEN  EX/MEM result
- memwb_rd_addr  in  RA_W  MEM/WB destination
- memwb_rd_we  in  1  MEM/WB writes a register
- memwb_result  in  XLEN  MEM/WB result
- out_valid  out  1  A/B/ALUCtrl valid for the ALU
- out_ready  in  1  downstream consumes this cycle
- out_a  out  XLEN  operand A to ALU
- out_b  out  XLEN  operand B to ALU
- out_alu_ctrl  out  CTRL_W  to ALU ALUCtrl
- out_rd_addr  out  RA_W  destination passed down
- out_rd_we  out  1  write enable passed down
- out_div0  out  1  held op is DIV (4'b0001) with out_b == 0

Behaviour:
- Reset (async, rst_n low): every output register clears to 0; out_valid=0; out_div0=0. Released synchronously to clk.
- in_ready = !out_valid || out_ready (combinational). Capture occurs when in_valid && in_ready && !flush. Latency: one cycle from capture to out_valid.
- State: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on capture.
  - FULL -> FULL on consume with simultaneous capture (back-to-back, no bubble).
  - FULL -> EMPTY on consume without capture.
  - FULL holds while out_ready=0.
- flush has priority over everything. The next state is EMPTY, out_rd_we=0, and any in_valid that cycle is dropped.
- Forwarding on capture, per source s:
  - EX/MEM if exmem_rd_we && exmem_rd_addr==s && s!=0;
  - else MEM/WB if memwb_rd_we && memwb_rd_addr==s && s!=0;
  - else the register-file data.
  - Source 0 is always forced to 0.
- Snoop while held: the stage keeps rs1/rs2 addresses and use_imm internally. Each FULL cycle without consume or capture, out_a is rewritten with the same priority rule when a match exists; otherwise it is unchanged. out_b is treated the same way only when use_imm=0.
- out_b = imm when use_imm=1. The immediate is never overwritten by snooping.
- out_div0 is registered and recomputed whenever out_b or out_alu_ctrl is written, so it always reflects the current held values.
- Both forwarding buses matching the same source: EX/MEM wins.

Decomposition:
- Shared package alu_pkg holds the ALU op constants: ADD 0010, SUB 0110, MUL 0011, DIV 0001, SLT 0111, AND 0000.
- It also holds the XLEN and RA_W defaults.
- One sub-module, fwd_select: purely combinational. Inputs are the source address, register data and both forward buses; output is the selected operand. It is instantiated twice, for rs1 and rs2.

Test Plan:
1. Reset mid-operation: FULL with out_a=5, assert rst_n=0 -> immediately out_valid=0, all outputs 0; in_ready=1 after release.
2. Forward priority: rs1=3, rf=0x11; exmem rd=3 result 0x22; memwb rd=3 result 0x33 -> out_a=0x22. Repeat with exmem_rd_we=0 -> out_a=0x33. Repeat with rs1=0 -> out_a=0.
3. Stall snoop: capture rs2=7 with use_imm=0 and data 0x1; hold out_ready=0; next cycle memwb writes rd=7 = 0x9 -> out_b=0x9. With use_imm=1 and imm=0x40 -> out_b stays 0x40.
4. Back-to-back: out_ready=1 and in_valid=1 continuously for 4 ops -> 4 consecutive out_valid cycles, in order, in_ready constantly 1.
5. Flush with in_valid: FULL, flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0 and the new op is not captured.
6. DIV by zero: capture ctrl=0001 with B=0 -> out_div0=1. Snoop then writes B=4 -> out_div0=0 the following cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants and the operand-stage state type.
// Imported by the operand stage and its forwarding selector.
package alu_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int RA_W_DEF   = 5;
    localparam int CTRL_W_DEF = 4;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_MUL = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_AND = 4'b0000;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// Combinational operand selector: EX/MEM result, then MEM/WB result, then
// the supplied register value; register x0 always reads as zero.
module fwd_select
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic [RA_W-1:0] src_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic [RA_W-1:0] exmem_rd_addr,
    input  logic            exmem_rd_we,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [RA_W-1:0] memwb_rd_addr,
    input  logic            memwb_rd_we,
    input  logic [XLEN-1:0] memwb_result,
    output logic [XLEN-1:0] operand
);

    always_comb begin
        operand = rf_data;
        if (src_addr == '0) begin
            operand = '0;
        end else if (exmem_rd_we && (exmem_rd_addr == src_addr)) begin
            operand = exmem_result;
        end else if (memwb_rd_we && (memwb_rd_addr == src_addr)) begin
            operand = memwb_result;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Single-entry ID/EX register in front of the ALU with result forwarding,
// immediate selection and forwarding-bus snooping while an entry is held.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int RA_W   = RA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   in_rs1_addr,
    input  logic [RA_W-1:0]   in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [CTRL_W-1:0] in_alu_ctrl,
    input  logic [RA_W-1:0]   in_rd_addr,
    input  logic              in_rd_we,
    input  logic              flush,
    input  logic [RA_W-1:0]   exmem_rd_addr,
    input  logic              exmem_rd_we,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [RA_W-1:0]   memwb_rd_addr,
    input  logic              memwb_rd_we,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [CTRL_W-1:0] out_alu_ctrl,
    output logic [RA_W-1:0]   out_rd_addr,
    output logic              out_rd_we,
    output logic              out_div0
);

    stage_state_t      state_reg, state_next;
    logic [XLEN-1:0]   a_reg, a_next;
    logic [XLEN-1:0]   b_reg, b_next;
    logic [CTRL_W-1:0] ctrl_reg, ctrl_next;
    logic [RA_W-1:0]   rd_addr_reg, rd_addr_next;
    logic              rd_we_reg, rd_we_next;
    logic              div0_reg, div0_next;
    logic [RA_W-1:0]   rs1_reg, rs1_next;
    logic [RA_W-1:0]   rs2_reg, rs2_next;
    logic              use_imm_reg, use_imm_next;

    logic capture;
    logic consume;

    logic [RA_W-1:0] sel_addr [2];
    logic [XLEN-1:0] sel_data [2];
    logic [XLEN-1:0] fwd_data [2];

    assign out_valid = (state_reg == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign capture   = in_valid && in_ready && !flush;
    assign consume   = out_valid && out_ready;

    // Snooping feeds the held operand back in as the "register value", so
    // a miss on both buses leaves the operand unchanged.
    always_comb begin
        if (capture) begin
            sel_addr[0] = in_rs1_addr;
            sel_addr[1] = in_rs2_addr;
            sel_data[0] = in_rs1_data;
            sel_data[1] = in_rs2_data;
        end else begin
            sel_addr[0] = rs1_reg;
            sel_addr[1] = rs2_reg;
            sel_data[0] = a_reg;
            sel_data[1] = b_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_select #(
                .XLEN (XLEN),
                .RA_W (RA_W)
            ) u_fwd_select (
                .src_addr      (sel_addr[gi]),
                .rf_data       (sel_data[gi]),
                .exmem_rd_addr (exmem_rd_addr),
                .exmem_rd_we   (exmem_rd_we),
                .exmem_result  (exmem_result),
                .memwb_rd_addr (memwb_rd_addr),
                .memwb_rd_we   (memwb_rd_we),
                .memwb_result  (memwb_result),
                .operand       (fwd_data[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        ctrl_next    = ctrl_reg;
        rd_addr_next = rd_addr_reg;
        rd_we_next   = rd_we_reg;
        rs1_next     = rs1_reg;
        rs2_next     = rs2_reg;
        use_imm_next = use_imm_reg;

        if (flush) begin
            state_next = ST_EMPTY;
            rd_we_next = 1'b0;
        end else if (capture) begin
            state_next   = ST_FULL;
            a_next       = fwd_data[0];
            b_next       = in_use_imm ? in_imm : fwd_data[1];
            ctrl_next    = in_alu_ctrl;
            rd_addr_next = in_rd_addr;
            rd_we_next   = in_rd_we;
            rs1_next     = in_rs1_addr;
            rs2_next     = in_rs2_addr;
            use_imm_next = in_use_imm;
        end else if (consume) begin
            state_next = ST_EMPTY;
        end else if (state_reg == ST_FULL) begin
            a_next = fwd_data[0];
            if (!use_imm_reg) begin
                b_next = fwd_data[1];
            end
        end

        // Derived from the next-cycle operands so it tracks every write.
        div0_next = (ctrl_next == CTRL_W'(ALU_DIV)) && (b_next == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_EMPTY;
            a_reg       <= '0;
            b_reg       <= '0;
            ctrl_reg    <= '0;
            rd_addr_reg <= '0;
            rd_we_reg   <= 1'b0;
            div0_reg    <= 1'b0;
            rs1_reg     <= '0;
            rs2_reg     <= '0;
            use_imm_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            ctrl_reg    <= ctrl_next;
            rd_addr_reg <= rd_addr_next;
            rd_we_reg   <= rd_we_next;
            div0_reg    <= div0_next;
            rs1_reg     <= rs1_next;
            rs2_reg     <= rs2_next;
            use_imm_reg <= use_imm_next;
        end
    end

    assign out_a        = a_reg;
    assign out_b        = b_reg;
    assign out_alu_ctrl = ctrl_reg;
    assign out_rd_addr  = rd_addr_reg;
    assign out_rd_we    = rd_we_reg;
    assign out_div0     = div0_reg;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [63:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm, in_rd_we, flush;
    logic [3:0]  in_alu_ctrl;
    logic [4:0]  exmem_rd_addr, memwb_rd_addr;
    logic        exmem_rd_we, memwb_rd_we;
    logic [63:0] exmem_result, memwb_result;
    logic        out_valid, out_ready;
    logic [63:0] out_a, out_b;
    logic [3:0]  out_alu_ctrl;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we, out_div0;

    int compared = 0;
    int mismatched = 0;

    // Model of the held entry
    logic        m_valid;
    logic [63:0] m_a, m_b;
    logic [3:0]  m_ctrl;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic        m_we, m_use_imm;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_ctrl(in_alu_ctrl),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we), .flush(flush),
        .exmem_rd_addr(exmem_rd_addr), .exmem_rd_we(exmem_rd_we), .exmem_result(exmem_result),
        .memwb_rd_addr(memwb_rd_addr), .memwb_rd_we(memwb_rd_we), .memwb_result(memwb_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_ctrl(out_alu_ctrl),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_div0(out_div0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] fwd(input logic [4:0] s, input logic [63:0] rf);
        if (s == 5'd0) return 64'd0;
        if (exmem_rd_we && exmem_rd_addr == s) return exmem_result;
        if (memwb_rd_we && memwb_rd_addr == s) return memwb_result;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_ctrl = 0; m_rd = 0; m_we = 0;
        m_rs1 = 0; m_rs2 = 0; m_use_imm = 0;
    endtask

    task automatic model_step();
        logic cap;
        cap = in_valid && (!m_valid || out_ready) && !flush;
        if (flush) begin
            m_valid = 0;
            m_we = 0;
        end else if (cap) begin
            m_valid = 1;
            m_a = fwd(in_rs1_addr, in_rs1_data);
            m_b = in_use_imm ? in_imm : fwd(in_rs2_addr, in_rs2_data);
            m_ctrl = in_alu_ctrl; m_rd = in_rd_addr; m_we = in_rd_we;
            m_rs1 = in_rs1_addr; m_rs2 = in_rs2_addr; m_use_imm = in_use_imm;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end else if (m_valid) begin
            m_a = fwd(m_rs1, m_a);
            if (!m_use_imm) m_b = fwd(m_rs2, m_b);
        end
    endtask

    // Compare at the falling edge, then advance the model with the inputs
    // that will be sampled at the coming rising edge.
    task automatic cycle();
        @(negedge clk);
        chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_a", out_a, m_a);
            chk("out_b", out_b, m_b);
            chk("out_alu_ctrl", 64'(out_alu_ctrl), 64'(m_ctrl));
            chk("out_rd_addr", 64'(out_rd_addr), 64'(m_rd));
            chk("out_rd_we", 64'(out_rd_we), 64'(m_we));
            chk("out_div0", 64'(out_div0), 64'(m_ctrl == 4'b0001 && m_b == 64'd0));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_imm = 0; in_use_imm = 0; in_alu_ctrl = 4'b0010; in_rd_addr = 0; in_rd_we = 0;
        flush = 0; exmem_rd_addr = 0; exmem_rd_we = 0; exmem_result = 0;
        memwb_rd_addr = 0; memwb_rd_we = 0; memwb_result = 0; out_ready = 1;
    endtask

    task automatic drain();
        idle();
        cycle();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_a"}, out_a, 64'd0);
        chk({tag, "_b"}, out_b, 64'd0);
        chk({tag, "_ctrl"}, 64'(out_alu_ctrl), 64'd0);
        chk({tag, "_rd"}, 64'(out_rd_addr), 64'd0);
        chk({tag, "_we"}, 64'(out_rd_we), 64'd0);
        chk({tag, "_div0"}, 64'(out_div0), 64'd0);
    endtask

    initial begin
        idle();
        rst_n = 0;
        model_reset();
        #12;
        check_all_zero("por");
        @(posedge clk); #1;
        rst_n = 1;
        chk("por_in_ready", 64'(in_ready), 64'd1);

        // Forwarding priority
        in_valid = 1; in_rs1_addr = 3; in_rs1_data = 64'h11;
        exmem_rd_addr = 3; exmem_rd_we = 1; exmem_result = 64'h22;
        memwb_rd_addr = 3; memwb_rd_we = 1; memwb_result = 64'h33;
        cycle();
        chk("fwd_exmem", out_a, 64'h22);
        exmem_rd_we = 0;
        cycle();
        chk("fwd_memwb", out_a, 64'h33);
        in_rs1_addr = 0;
        cycle();
        chk("fwd_x0", out_a, 64'h0);
        $display("txn fwd_priority done");

        // Stall snoop on rs2
        drain();
        in_valid = 1; in_rs2_addr = 7; in_rs2_data = 64'h1; out_ready = 0;
        cycle();
        chk("snoop_cap_b", out_b, 64'h1);
        in_valid = 0; memwb_rd_addr = 7; memwb_rd_we = 1; memwb_result = 64'h9;
        cycle();
        chk("snoop_b", out_b, 64'h9);
        drain();
        in_valid = 1; in_rs2_addr = 7; in_use_imm = 1; in_imm = 64'h40; out_ready = 0;
        cycle();
        in_valid = 0; memwb_rd_addr = 7; memwb_rd_we = 1; memwb_result = 64'h9;
        cycle();
        chk("snoop_imm_b", out_b, 64'h40);
        $display("txn stall_snoop done");

        // Back-to-back
        drain();
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1; in_use_imm = 1; in_imm = 64'(k * 16); in_rd_addr = 5'(k);
            out_ready = 1;
            chk("b2b_in_ready", 64'(in_ready), 64'd1);
            cycle();
            chk("b2b_valid", 64'(out_valid), 64'd1);
            chk("b2b_b", out_b, 64'(k * 16));
            $display("txn b2b op=%0d b=%h", k, out_b);
        end

        // Flush with a concurrent request
        drain();
        in_valid = 1; in_rd_we = 1; in_rd_addr = 9; out_ready = 0;
        cycle();
        flush = 1; in_rd_addr = 10; in_valid = 1;
        cycle();
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_we", 64'(out_rd_we), 64'd0);
        $display("txn flush done");

        // Divide by zero tracking
        drain();
        in_valid = 1; in_alu_ctrl = 4'b0001; in_rs2_addr = 5; in_rs2_data = 0; out_ready = 0;
        cycle();
        chk("div0_set", 64'(out_div0), 64'd1);
        in_valid = 0; memwb_rd_addr = 5; memwb_rd_we = 1; memwb_result = 64'h4;
        cycle();
        chk("div0_clr_b", out_b, 64'h4);
        chk("div0_clr", 64'(out_div0), 64'd0);
        $display("txn div0 done");

        // Reset mid-operation
        drain();
        in_valid = 1; in_rs1_addr = 1; in_rs1_data = 64'h5; out_ready = 0;
        cycle();
        chk("rst_pre_a", out_a, 64'h5);
        idle();
        rst_n = 0;
        #1;
        model_reset();
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        $display("txn reset_mid done");

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_rs1_addr = 5'($urandom_range(0, 7));
            in_rs2_addr = 5'($urandom_range(0, 7));
            in_rs1_data = {$urandom, $urandom};
            in_rs2_data = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            in_imm = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            in_use_imm = $urandom_range(0, 1) == 1;
            in_alu_ctrl = ($urandom_range(0, 1) == 1) ? 4'b0001 : 4'($urandom);
            in_rd_addr = 5'($urandom);
            in_rd_we = $urandom_range(0, 1) == 1;
            flush = ($urandom_range(0, 15) == 0);
            exmem_rd_addr = 5'($urandom_range(0, 7));
            exmem_rd_we = $urandom_range(0, 1) == 1;
            exmem_result = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            memwb_rd_addr = 5'($urandom_range(0, 7));
            memwb_rd_we = $urandom_range(0, 1) == 1;
            memwb_result = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (n % 500 == 0)
                $display("txn random n=%0d valid=%0d a=%h b=%h", n, out_valid, out_a, out_b);
        end

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
